// File: rtl/mult_pkg.sv
// Shared types and default sizing for the shared sequential multiplier.
package mult_pkg;

    localparam int unsigned MULT_WIDTH   = 4;
    localparam int unsigned MULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward from last_grant+1.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((32'(last_grant_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// One shift-add multiplier time-shared among NUM_REQ requesters with a round-robin grant.
module mult_share_sched
    import mult_pkg::*;
#(
    parameter int unsigned NUM_REQ = MULT_NUM_REQ,
    parameter int unsigned WIDTH   = MULT_WIDTH,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_product,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [WIDTH-1:0]   a_sel, b_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // Mux the granted lane with constant slices so the one-hot grant drives the select.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        last_d    = last_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    a_d       = a_sel;
                    b_d       = b_sel;
                    id_d      = grant_idx;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign rsp_valid   = (state_q == RESP);
    assign rsp_product = acc_q;
    assign rsp_id      = id_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed tables and sequences plus random traffic vs a transaction model.
module tb_mult_share_sched;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [2*W-1:0]   rsp_product;
    logic [IW-1:0]    rsp_id;
    logic             busy;

    mult_share_sched #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Samples taken at the falling edge of the most recent cycle.
    logic [N-1:0]   s_req_ready;
    logic           s_rsp_valid, s_busy;
    logic [2*W-1:0] s_prod;
    logic [IW-1:0]  s_id;

    // Transaction-level reference: owner, product and cycles left, not the RTL encoding.
    bit m_armed = 0;
    bit m_busy, m_resp, m_clean;
    int m_left, m_id, m_prod, m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int off = 1; off <= N; off++) begin
            if (v[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] exp_ready;
        int g;
        if (m_armed) begin
            exp_ready = '0;
            g = pick(req_valid, m_ptr);
            if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
            chk("m_req_ready", 32'(s_req_ready), 32'(exp_ready));
            chk("m_busy", 32'(s_busy), 32'(m_busy));
            chk("m_rsp_valid", 32'(s_rsp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("m_rsp_product", 32'(s_prod), 32'(m_prod));
                chk("m_rsp_id", 32'(s_id), 32'(m_id));
            end else if (m_clean) begin
                chk("m_reset_product", 32'(s_prod), 0);
                chk("m_reset_id", 32'(s_id), 0);
            end
        end
        if (reset) begin
            m_armed = 1; m_busy = 0; m_resp = 0; m_clean = 1; m_ptr = N - 1;
        end else if (m_armed) begin
            if (!m_busy) begin
                g = pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_busy  = 1;
                    m_left  = W;
                    m_id    = g;
                    m_prod  = int'(req_a[g*W +: W]) * int'(req_b[g*W +: W]);
                    m_clean = 0;
                end
            end else if (!m_resp) begin
                m_left--;
                if (m_left == 0) m_resp = 1;
            end else if (rsp_ready) begin
                m_ptr  = m_id;
                m_busy = 0;
                m_resp = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_prod      = rsp_product;
        s_id        = rsp_id;
        s_busy      = busy;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; req_valid = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0; rsp_ready = 1'b1;
        do begin tick(); n++; end while (s_busy && n < 40);
        chk("drain_idle", 32'(s_busy), 0);
    endtask

    task automatic single(input int id, input int a, input int b, input int exp, input string nm);
        logic [N-1:0] oh;
        int lat = 0;
        bit got = 0;
        oh = '0; oh[id] = 1'b1;
        req_a = N*W'($urandom); req_b = N*W'($urandom);
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        req_valid = oh; rsp_ready = 1'b1;
        tick();
        chk({nm, "_grant"}, 32'(s_req_ready), 32'(oh));
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 4'd9;
            req_b[i*W +: W] = 4'd7;
        end
        while (!got && lat < 20) begin
            tick(); lat++;
            if (s_rsp_valid) got = 1;
        end
        chk({nm, "_latency"}, 32'(lat), W + 1);
        chk({nm, "_product"}, 32'(s_prod), 32'(exp));
        chk({nm, "_id"}, 32'(s_id), 32'(id));
    endtask

    typedef struct {
        int    id;
        int    a;
        int    b;
        int    prod;
        string nm;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int order[5];
        int exp_order[5];
        int ng, nr, gi;

        tbl[0] = '{2, 13, 11, 143, "t13x11"};
        tbl[1] = '{1, 15, 15, 225, "t15x15"};
        tbl[2] = '{0, 0, 9, 0, "t0x9"};
        tbl[3] = '{3, 7, 0, 0, "t7x0"};
        tbl[4] = '{2, 5, 3, 15, "t5x3_opchange"};
        tbl[5] = '{0, 1, 1, 1, "t1x1"};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset values.
        reset_dut();
        tick();
        chk("rst_req_ready", 32'(s_req_ready), 0);
        chk("rst_rsp_valid", 32'(s_rsp_valid), 0);
        chk("rst_product", 32'(s_prod), 0);
        chk("rst_id", 32'(s_id), 0);
        chk("rst_busy", 32'(s_busy), 0);

        for (int i = 0; i < 6; i++) single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].prod, tbl[i].nm);

        // All requesters valid continuously.
        reset_dut();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 2);
            req_b[i*W +: W] = W'(i + 3);
        end
        order = '{-1, -1, -1, -1, -1};
        req_valid = '1; rsp_ready = 1'b1;
        ng = 0; nr = 0;
        for (int t = 0; t < 80 && ng < 5; t++) begin
            tick();
            if (s_rsp_valid && nr < ng) begin
                gi = order[nr];
                chk("rr_rsp_id", 32'(s_id), 32'(gi));
                chk("rr_rsp_product", 32'(s_prod), 32'((gi + 2) * (gi + 3)));
                nr++;
            end
            if (s_req_ready != '0) begin
                chk("rr_onehot", 32'($countones(s_req_ready)), 1);
                order[ng] = oh2idx(s_req_ready);
                ng++;
            end
        end
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(order[k]), 32'(exp_order[k]));
        drain();

        // Backpressure.
        reset_dut();
        req_a[1*W +: W] = 4'd6; req_b[1*W +: W] = 4'd7;
        req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();
        req_valid = '1;
        ng = 0;
        while (!s_rsp_valid && ng < 20) begin tick(); ng++; end
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_rsp_valid", 32'(s_rsp_valid), 1);
            chk("bp_product", 32'(s_prod), 42);
            chk("bp_id", 32'(s_id), 1);
            chk("bp_req_ready", 32'(s_req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_ready", 32'(s_req_ready), 0);
        tick();
        chk("bp_next_grant", 32'(s_req_ready), 32'(4'b0100));
        drain();

        // Reset in the middle of RUN.
        reset_dut();
        single(1, 2, 2, 4, "pre_rst");
        req_a[2*W +: W] = 4'd3; req_b[2*W +: W] = 4'd3;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rst_mid_no_rsp", 32'(s_rsp_valid), 0);
        end
        req_valid = '1;
        tick();
        chk("rst_prio0", 32'(s_req_ready), 32'(4'b0001));
        drain();
        reset_dut();
        single(3, 2, 5, 10, "rst_req3");

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1; req_valid = '0;
            end else begin
                reset = 1'b0;
                req_valid = N'($urandom);
            end
            req_a = N*W'($urandom);
            req_b = N*W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
